// File: rtl/polyconv_pkg.sv
// Shared types and GF(2) arithmetic for the 2-parallel polyphase convolution slice.
// All products are carry-less; addition is XOR throughout.
package polyconv_pkg;

  localparam int DW = 4;
  localparam int PW = 2 * DW - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic logic [PW-1:0] clmul4(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [PW-1:0] acc;
    acc = '0;
    for (int i = 0; i < DW; i++) begin
      if (b[i]) acc = acc ^ ({{(PW-DW){1'b0}}, a} << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/polyphase_core.sv
// Combinational 2-parallel polyphase GF(2) convolution kernel.
// y2 is the tail that spills into the next block and is overlap-added by the sequencer.
module polyphase_core
  import polyconv_pkg::*;
(
  input  logic [DW-1:0] x0,
  input  logic [DW-1:0] x1,
  input  logic [DW-1:0] h0,
  input  logic [DW-1:0] h1,
  output logic [PW-1:0] y0,
  output logic [PW-1:0] y1,
  output logic [PW-1:0] y2
);

  assign y0 = clmul4(x0, h0);
  assign y1 = clmul4(x0, h1) ^ clmul4(x1, h0);
  assign y2 = clmul4(x1, h1);

endmodule

// File: rtl/polyconv_sequencer.sv
// Streaming controller around polyphase_core: holds coefficients, overlap-adds the
// y2 tail into the next block and emits a final tail beat after the last block.
module polyconv_sequencer
  import polyconv_pkg::*;
#(
  parameter int DW    = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [DW-1:0]    cfg_h0,
  input  logic [DW-1:0]    cfg_h1,
  output logic             cfg_err,
  input  logic             start,
  output logic             busy,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_x0,
  input  logic [DW-1:0]    s_x1,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PW-1:0]    m_y0,
  output logic [PW-1:0]    m_y1,
  output logic             m_last,
  output logic [CNT_W-1:0] blk_cnt
);

  state_t        state;
  logic [DW-1:0] h0, h1;
  logic [PW-1:0] carry;
  logic [PW-1:0] y0, y1, y2;
  logic          slot_free;
  logic          accept;

  polyphase_core u_core (
    .x0 (s_x0),
    .x1 (s_x1),
    .h0 (h0),
    .h1 (h1),
    .y0 (y0),
    .y1 (y1),
    .y2 (y2)
  );

  // The output register is the only buffer, so a new load needs it empty or draining.
  assign slot_free = !m_valid || m_ready;
  assign s_ready   = (state == RUN) && slot_free;
  assign accept    = s_valid && s_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      h0      <= '0;
      h1      <= '0;
      carry   <= '0;
      m_y0    <= '0;
      m_y1    <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      cfg_err <= 1'b0;
      blk_cnt <= '0;
    end else begin
      cfg_err <= cfg_we && (state != IDLE);
      if (m_ready) m_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (cfg_we) begin
            h0 <= cfg_h0;
            h1 <= cfg_h1;
          end
          if (start) begin
            carry   <= '0;
            blk_cnt <= '0;
            state   <= RUN;
          end
        end

        RUN: begin
          if (accept) begin
            m_y0    <= y0 ^ carry;
            m_y1    <= y1;
            m_last  <= 1'b0;
            m_valid <= 1'b1;
            carry   <= y2;
            blk_cnt <= blk_cnt + CNT_W'(1);
            if (s_last) state <= FLUSH;
          end
        end

        FLUSH: begin
          if (slot_free) begin
            m_y0    <= carry;
            m_y1    <= '0;
            m_last  <= 1'b1;
            m_valid <= 1'b1;
            carry   <= '0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_polyconv_sequencer.sv
// Scoreboard bench for polyconv_sequencer: the reference treats each stream as one
// word sequence convolved with {h0,h1} over GF(2) and slices the result into beats.
module tb_polyconv_sequencer;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [3:0]       cfg_h0, cfg_h1;
  logic             cfg_err;
  logic             start;
  logic             busy;
  logic             s_valid;
  logic             s_ready;
  logic [3:0]       s_x0, s_x1;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [6:0]       m_y0, m_y1;
  logic             m_last;
  logic [CNT_W-1:0] blk_cnt;

  always #5 clk = ~clk;

  polyconv_sequencer #(.DW(4), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_we  (cfg_we),
    .cfg_h0  (cfg_h0),
    .cfg_h1  (cfg_h1),
    .cfg_err (cfg_err),
    .start   (start),
    .busy    (busy),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_x0    (s_x0),
    .s_x1    (s_x1),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_y0    (m_y0),
    .m_y1    (m_y1),
    .m_last  (m_last),
    .blk_cnt (blk_cnt)
  );

  typedef struct packed {
    logic [6:0] y0;
    logic [6:0] y1;
    logic       last;
  } beat_t;

  beat_t      expq[$];
  logic [3:0] words[$];
  logic [3:0] mh0, mh1;
  int         nblk;
  int         checks = 0;
  int         errors = 0;
  int         last_wait;
  logic       rdy_rand = 1'b0;
  logic       rdy_level = 1'b1;

  // Plain polynomial product over GF(2): bit i of a times bit j of b lands on i+j.
  function automatic logic [6:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[i+j] = r[i+j] ^ (a[i] & b[j]);
    return r;
  endfunction

  // Word n of (word stream) * (h0 + h1*z), with words outside the stream taken as zero.
  function automatic logic [6:0] conv_word(input int n);
    logic [6:0] r;
    logic [3:0] h[2];
    r = '0;
    h[0] = mh0;
    h[1] = mh1;
    for (int t = 0; t < 2; t++) begin
      if (n - t >= 0 && n - t < words.size()) r = r ^ gmul(words[n-t], h[t]);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready: either a fixed level or random backpressure.
  always @(posedge clk) begin
    #2;
    m_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_level;
  end

  // Monitor: pops the scoreboard on every handshake and checks stability under stall.
  beat_t      mon_e;
  logic       pend = 1'b0;
  logic [14:0] pend_val;
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'({m_y0, m_y1, m_last}), 32'(pend_val));
      end
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat got y0=%0h y1=%0h last=%0b want none", m_y0, m_y1, m_last);
        end else begin
          mon_e = expq.pop_front();
          check("beat_y0", 32'(m_y0), 32'(mon_e.y0));
          check("beat_y1", 32'(m_y1), 32'(mon_e.y1));
          check("beat_last", 32'(m_last), 32'(mon_e.last));
        end
      end
      pend = m_valid && !m_ready;
      pend_val = {m_y0, m_y1, m_last};
    end
  end

  task automatic drive(input logic [3:0] x0, input logic [3:0] x1, input logic last);
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_x0 = x0;
    s_x1 = x1;
    s_last = last;
  endtask

  // Waits for the block on the bus to be taken and records its expected beats.
  task automatic wait_accept();
    int k;
    bit ok;
    ok = 0;
    last_wait = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      last_wait++;
      if (s_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      words.push_back(s_x0);
      words.push_back(s_x1);
      nblk++;
      k = words.size() / 2 - 1;
      expq.push_back('{y0: conv_word(2*k), y1: conv_word(2*k+1), last: 1'b0});
      if (s_last) expq.push_back('{y0: conv_word(2*k+2), y1: 7'd0, last: 1'b1});
    end
  endtask

  task automatic send(input logic [3:0] x0, input logic [3:0] x1, input logic last);
    drive(x0, x1, last);
    wait_accept();
  endtask

  task automatic idle_inputs();
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic begin_stream(input logic [3:0] h0, input logic [3:0] h1, input bit same);
    wait_idle();
    @(posedge clk); #1;
    cfg_we = 1'b1;
    cfg_h0 = h0;
    cfg_h1 = h1;
    start = same;
    if (!same) begin
      @(posedge clk); #1;
      cfg_we = 1'b0;
      start = 1'b1;
    end
    @(posedge clk); #1;
    cfg_we = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("cfg_err_idle", 32'(cfg_err), 32'd0);
    check("busy_run", 32'(busy), 32'd1);
    mh0 = h0;
    mh1 = h1;
    words.delete();
    nblk = 0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (expq.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'(expq.size()), 32'd0);
    check("blk_cnt", 32'(blk_cnt), 32'(nblk % (1 << CNT_W)));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    cfg_we = 1'b0; cfg_h0 = '0; cfg_h1 = '0;
    start = 1'b0;
    s_valid = 1'b0; s_x0 = '0; s_x1 = '0; s_last = 1'b0;
    m_ready = 1'b1;
    nblk = 0; mh0 = '0; mh1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_blk_cnt", 32'(blk_cnt), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_y0", 32'({m_y0, m_y1, m_last}), 32'd0);

    // T1: single block, tail beat follows
    begin_stream(4'h3, 4'h0, 1'b0);
    send(4'h3, 4'h0, 1'b1);
    idle_inputs();
    drain();

    // T2: overlap-add across two blocks, back-to-back; cfg and start in the same cycle
    begin_stream(4'h1, 4'h1, 1'b1);
    send(4'hF, 4'hF, 1'b0);
    send(4'h1, 4'h0, 1'b1);
    check("back_to_back", 32'(last_wait), 32'd1);
    idle_inputs();
    drain();

    // T3: stall after the first beat
    begin_stream(4'h1, 4'h1, 1'b0);
    send(4'hF, 4'hF, 1'b0);
    @(posedge clk); #1;
    rdy_level = 1'b0;
    s_valid = 1'b1; s_x0 = 4'h1; s_x1 = 4'h0; s_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_s_ready", 32'(s_ready), 32'd0);
      check("stall_m_y0", 32'(m_y0), 32'h0F);
    end
    @(posedge clk); #1;
    rdy_level = 1'b1;
    wait_accept();
    idle_inputs();
    drain();

    // T4: coefficient write during RUN is rejected
    begin_stream(4'h2, 4'h5, 1'b0);
    send(4'h9, 4'h6, 1'b0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    cfg_we = 1'b1; cfg_h0 = 4'h7; cfg_h1 = 4'hC;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(negedge clk);
    check("cfg_err_pulse", 32'(cfg_err), 32'd1);
    @(negedge clk);
    check("cfg_err_drop", 32'(cfg_err), 32'd0);
    send(4'hB, 4'h3, 1'b1);
    idle_inputs();
    drain();

    // T5: reset mid-RUN with a beat pending
    begin_stream(4'h5, 4'hA, 1'b0);
    send(4'h4, 4'h7, 1'b0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    rdy_level = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    expq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_level = 1'b1;
    @(negedge clk);
    check("rst_mid_m_valid", 32'(m_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_blk_cnt", 32'(blk_cnt), 32'd0);

    // T6: counter wrap with CNT_W=2, random backpressure
    rdy_rand = 1'b1;
    begin_stream(4'($urandom), 4'($urandom), 1'b1);
    for (int i = 0; i < 5; i++) send(4'($urandom), 4'($urandom), i == 4);
    idle_inputs();
    drain();

    // Random streams with bubbles and backpressure
    for (int s = 0; s < 8; s++) begin
      begin_stream(4'($urandom), 4'($urandom), 1'($urandom));
      n = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle_inputs();
        send(4'($urandom), 4'($urandom), i == n - 1);
      end
      idle_inputs();
      drain();
    end

    rdy_rand = 1'b0;
    repeat (4) @(posedge clk);
    check("final_queue", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
